// File: rtl/mainmemory_pipe_if.sv
// Request/response bundle between a memory client (master) and mainmemory_pipe (slave).
interface mainmemory_pipe_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 27
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W/8-1:0]   req_be;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_err;
  logic                  wr_err;

  modport master (
    output req_valid, req_write, req_addr, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_err, wr_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_err, wr_err
  );
endinterface

// File: rtl/mainmemory_pipe.sv
// Line-wide backing memory with valid/ready requests, byte enables, pipelined reads and write throttling.
// Optional feature macro: MAINMEM_STATS_EN adds saturating stat_rd/stat_wr/stat_stall counters.
module mainmemory_pipe #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 27,
  parameter int ENTRIES    = 256,
  parameter int READ_LAT   = 2,
  parameter int WRITE_TPUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mainmemory_pipe_if.slave bus
`ifdef MAINMEM_STATS_EN
  ,
  output logic [31:0]      stat_rd,
  output logic [31:0]      stat_wr,
  output logic [31:0]      stat_stall
`endif
);
  localparam int BE_W   = DATA_W / 8;
  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int WCNT_W = $clog2(WRITE_TPUT + 1);
  localparam logic [ADDR_W:0] ENTRIES_A = (ADDR_W + 1)'(ENTRIES);

  typedef enum logic [0:0] {OPEN = 1'b0, WBUSY = 1'b1} state_e;

  logic [DATA_W-1:0] mem [ENTRIES];

  logic              accept;
  logic              acc_rd;
  logic              acc_wr;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              ready_q, ready_d;
  logic              wr_err_q, wr_err_d;

  logic [READ_LAT-1:0] pv_q, pv_d;
  logic [READ_LAT-1:0] pe_q, pe_d;
  logic [DATA_W-1:0]   pd_q [READ_LAT];
  logic [DATA_W-1:0]   pd_d [READ_LAT];

  // Full-width unsigned compare so high address bits can never alias into the array.
  assign accept   = bus.req_valid & ready_q;
  assign acc_rd   = accept & ~bus.req_write;
  assign acc_wr   = accept & bus.req_write;
  assign in_range = ({1'b0, bus.req_addr} < ENTRIES_A);
  assign idx      = bus.req_addr[IDX_W-1:0];

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = pv_q[READ_LAT-1];
  assign bus.rsp_err   = pe_q[READ_LAT-1];
  assign bus.rsp_data  = pd_q[READ_LAT-1];
  assign bus.wr_err    = wr_err_q;

  // Write throttle next-state; ready is registered so it is low throughout reset.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      OPEN: begin
        if (acc_wr && (WRITE_TPUT > 1)) begin
          state_d = WBUSY;
          wcnt_d  = WCNT_W'(WRITE_TPUT - 1);
        end else begin
          state_d = OPEN;
        end
      end
      WBUSY: begin
        wcnt_d = wcnt_q - {{(WCNT_W-1){1'b0}}, 1'b1};
        if (wcnt_q == {{(WCNT_W-1){1'b0}}, 1'b1}) begin
          state_d = OPEN;
        end else begin
          state_d = WBUSY;
        end
      end
      default: begin
        state_d = OPEN;
        wcnt_d  = '0;
      end
    endcase
    ready_d  = (state_d == OPEN);
    wr_err_d = acc_wr & ~in_range;
  end

  // Read pipeline: stage 0 samples the array at acceptance, later stages just shift.
  always_comb begin
    pv_d    = '0;
    pe_d    = '0;
    pv_d[0] = acc_rd;
    pe_d[0] = acc_rd & ~in_range;
    pd_d[0] = (acc_rd && in_range) ? mem[idx] : '0;
    for (int i = 1; i < READ_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OPEN;
      wcnt_q   <= '0;
      ready_q  <= 1'b0;
      wr_err_q <= 1'b0;
      pv_q     <= '0;
      pe_q     <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      ready_q  <= ready_d;
      wr_err_q <= wr_err_d;
      pv_q     <= pv_d;
      pe_q     <= pe_d;
      for (int i = 0; i < READ_LAT; i++) begin
        pd_q[i] <= pd_d[i];
      end
    end
  end

  // Array contents survive reset; only enabled bytes of in-range writes commit.
  always_ff @(posedge clk) begin
    if (acc_wr && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) begin
          mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Simulation-only report of out-of-range accesses.
  always_ff @(posedge clk) begin
    if (accept && !in_range) begin
      $warning("mainmemory_pipe: out-of-range %s at addr 0x%h",
               bus.req_write ? "write" : "read", bus.req_addr);
    end
  end
`endif

`ifdef MAINMEM_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d;
  logic [31:0] stat_wr_q, stat_wr_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic        stall;

  assign stall      = bus.req_valid & ~ready_q;
  assign stat_rd    = stat_rd_q;
  assign stat_wr    = stat_wr_q;
  assign stat_stall = stat_stall_q;

  // Saturating event counters.
  always_comb begin
    stat_rd_d    = (acc_rd && (stat_rd_q != 32'hFFFF_FFFF)) ? stat_rd_q + 32'd1 : stat_rd_q;
    stat_wr_d    = (acc_wr && (stat_wr_q != 32'hFFFF_FFFF)) ? stat_wr_q + 32'd1 : stat_wr_q;
    stat_stall_d = (stall && (stat_stall_q != 32'hFFFF_FFFF)) ? stat_stall_q + 32'd1 : stat_stall_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_q    <= 32'd0;
      stat_wr_q    <= 32'd0;
      stat_stall_q <= 32'd0;
    end else begin
      stat_rd_q    <= stat_rd_d;
      stat_wr_q    <= stat_wr_d;
      stat_stall_q <= stat_stall_d;
    end
  end
`endif
endmodule
